// File: rtl/johnson_phase_decoder.sv
// johnson_phase_decoder
// Samples a raw Johnson count, decodes it to a phase index and a one-hot
// vector, checks that each sample legally follows the previous one, tracks
// lock, and reports step errors, revolution wraps and a saturating error count.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   en           sample enable; count_in is evaluated only when en=1
//   count_in     raw Johnson count (WIDTH bits)
//   clear_err    synchronous clear of err_count (and wrap_count), works regardless of en
//   phase_idx    decoded phase 0..2*WIDTH-1 (holds on illegal samples)
//   phase_onehot one-hot of phase_idx, zero when valid_code=0
//   valid_code   last sample was a legal code
//   locked       sequence tracking is locked
//   step_err     one-cycle pulse on a sequencing error
//   wrap_pulse   one-cycle pulse on the last-to-first phase advance while locked
//   err_count    saturating count of step_err pulses
//   wrap_count   (JOHNSON_PHASE_WRAP_CNT_EN only) 16-bit wrapping count of wrap_pulse
//
// Optional feature macro: JOHNSON_PHASE_WRAP_CNT_EN
module johnson_phase_decoder #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned ERR_CNT_W  = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic [WIDTH-1:0]             count_in,
    input  logic                         clear_err,
    output logic [$clog2(2*WIDTH)-1:0]   phase_idx,
    output logic [2*WIDTH-1:0]           phase_onehot,
    output logic                         valid_code,
    output logic                         locked,
    output logic                         step_err,
    output logic                         wrap_pulse,
    output logic [ERR_CNT_W-1:0]         err_count
`ifdef JOHNSON_PHASE_WRAP_CNT_EN
    ,
    output logic [15:0]                  wrap_count
`endif
);

    localparam int unsigned NPH   = 2 * WIDTH;
    localparam int unsigned IDX_W = $clog2(NPH);
    localparam int unsigned RUN_W = 4;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     ref_q, ref_d;
    logic [RUN_W-1:0]     run_q, run_d;
    logic [IDX_W-1:0]     phase_idx_q, phase_idx_d;
    logic [NPH-1:0]       phase_onehot_q, phase_onehot_d;
    logic                 valid_code_q, valid_code_d;
    logic                 locked_q, locked_d;
    logic                 step_err_q, step_err_d;
    logic                 wrap_pulse_q, wrap_pulse_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    logic                 dec_valid;
    logic [IDX_W-1:0]     dec_idx;
    logic [NPH-1:0]       dec_onehot;
    logic [IDX_W-1:0]     ref_next;
    logic [RUN_W-1:0]     run_inc;
    logic                 is_adv;
    logic                 is_stall;

    // Legal code for phase k: k LSBs set for k<=N, otherwise the low k-N bits clear.
    function automatic logic [WIDTH-1:0] code_of(input int unsigned k);
        logic [WIDTH-1:0] c;
        c = '0;
        for (int unsigned b = 0; b < WIDTH; b++) begin
            if (k <= WIDTH) c[b] = (b < k);
            else            c[b] = (b >= k - WIDTH);
        end
        return c;
    endfunction

    // Decode the raw sample against all legal codes.
    always_comb begin
        dec_valid  = 1'b0;
        dec_idx    = '0;
        dec_onehot = '0;
        for (int unsigned k = 0; k < NPH; k++) begin
            if (count_in == code_of(k)) begin
                dec_valid     = 1'b1;
                dec_idx       = IDX_W'(k);
                dec_onehot[k] = 1'b1;
            end
        end
    end

    assign ref_next = (ref_q == IDX_W'(NPH - 1)) ? '0 : ref_q + IDX_W'(1);
    assign run_inc  = run_q + RUN_W'(1);
    assign is_adv   = dec_valid && (dec_idx == ref_next);
    assign is_stall = dec_valid && (dec_idx == ref_q);

    // Next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        ref_d          = ref_q;
        run_d          = run_q;
        phase_idx_d    = phase_idx_q;
        phase_onehot_d = phase_onehot_q;
        valid_code_d   = valid_code_q;
        step_err_d     = 1'b0;
        wrap_pulse_d   = 1'b0;
        err_count_d    = err_count_q;

        if (en) begin
            valid_code_d   = dec_valid;
            phase_onehot_d = dec_valid ? dec_onehot : '0;
            if (dec_valid) phase_idx_d = dec_idx;

            case (state_q)
                ST_SEARCH: begin
                    if (dec_valid) begin
                        state_d = ST_TRACK;
                        ref_d   = dec_idx;
                        run_d   = '0;
                    end
                end
                ST_TRACK, ST_LOCKED: begin
                    if (!dec_valid) begin
                        step_err_d = 1'b1;
                        state_d    = ST_SEARCH;
                        run_d      = '0;
                    end else if (is_adv) begin
                        ref_d = dec_idx;
                        if (state_q == ST_TRACK) begin
                            run_d = run_inc;
                            if (run_inc == RUN_W'(LOCK_COUNT)) state_d = ST_LOCKED;
                        end else if (ref_q == IDX_W'(NPH - 1) && dec_idx == '0) begin
                            wrap_pulse_d = 1'b1;
                        end
                    end else if (!is_stall) begin
                        // Legal but out-of-sequence: resynchronise on the new code.
                        step_err_d = 1'b1;
                        state_d    = ST_TRACK;
                        run_d      = '0;
                        ref_d      = dec_idx;
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end

        locked_d = (state_d == ST_LOCKED);

        // Clear takes priority over a coincident error.
        if (clear_err)                             err_count_d = '0;
        else if (step_err_d && err_count_q != '1)  err_count_d = err_count_q + ERR_CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_SEARCH;
            ref_q          <= '0;
            run_q          <= '0;
            phase_idx_q    <= '0;
            phase_onehot_q <= '0;
            valid_code_q   <= 1'b0;
            locked_q       <= 1'b0;
            step_err_q     <= 1'b0;
            wrap_pulse_q   <= 1'b0;
            err_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            ref_q          <= ref_d;
            run_q          <= run_d;
            phase_idx_q    <= phase_idx_d;
            phase_onehot_q <= phase_onehot_d;
            valid_code_q   <= valid_code_d;
            locked_q       <= locked_d;
            step_err_q     <= step_err_d;
            wrap_pulse_q   <= wrap_pulse_d;
            err_count_q    <= err_count_d;
        end
    end

    assign phase_idx    = phase_idx_q;
    assign phase_onehot = phase_onehot_q;
    assign valid_code   = valid_code_q;
    assign locked       = locked_q;
    assign step_err     = step_err_q;
    assign wrap_pulse   = wrap_pulse_q;
    assign err_count    = err_count_q;

`ifdef JOHNSON_PHASE_WRAP_CNT_EN
    logic [15:0] wrap_count_q, wrap_count_d;

    // Revolution counter; wraps naturally at 16 bits, clear wins.
    always_comb begin
        wrap_count_d = wrap_count_q;
        if (clear_err)         wrap_count_d = '0;
        else if (wrap_pulse_d) wrap_count_d = wrap_count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) wrap_count_q <= '0;
        else        wrap_count_q <= wrap_count_d;
    end

    assign wrap_count = wrap_count_q;
`endif

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Bench for johnson_phase_decoder: directed scenarios plus a randomized
// stream, compared every cycle against a behavioural model. A second
// instance with a 2-bit error counter shares the stimulus.
module tb_johnson_phase_decoder;

    localparam int NPH   = 8;
    localparam int LOCKN = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       clear_err = 1'b0;
    logic [3:0] count_in = 4'd0;

    logic [2:0] phase_idx,    s_phase_idx;
    logic [7:0] phase_onehot, s_phase_onehot;
    logic       valid_code,   s_valid_code;
    logic       locked,       s_locked;
    logic       step_err,     s_step_err;
    logic       wrap_pulse,   s_wrap_pulse;
    logic [7:0] err_count;
    logic [1:0] err_count_s;
`ifdef JOHNSON_PHASE_WRAP_CNT_EN
    logic [15:0] wrap_count, s_wrap_count;
`endif

    johnson_phase_decoder #(.WIDTH(4), .LOCK_COUNT(4), .ERR_CNT_W(8)) dut (
        .clk(clk), .reset(reset), .en(en), .count_in(count_in), .clear_err(clear_err),
        .phase_idx(phase_idx), .phase_onehot(phase_onehot), .valid_code(valid_code),
        .locked(locked), .step_err(step_err), .wrap_pulse(wrap_pulse), .err_count(err_count)
`ifdef JOHNSON_PHASE_WRAP_CNT_EN
        , .wrap_count(wrap_count)
`endif
    );

    johnson_phase_decoder #(.WIDTH(4), .LOCK_COUNT(4), .ERR_CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .en(en), .count_in(count_in), .clear_err(clear_err),
        .phase_idx(s_phase_idx), .phase_onehot(s_phase_onehot), .valid_code(s_valid_code),
        .locked(s_locked), .step_err(s_step_err), .wrap_pulse(s_wrap_pulse), .err_count(err_count_s)
`ifdef JOHNSON_PHASE_WRAP_CNT_EN
        , .wrap_count(s_wrap_count)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;

    // Legal sequence, phase 0..7.
    logic [3:0] codes [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                              4'b1111, 4'b1110, 4'b1100, 4'b1000};

    // Behavioural model state.
    bit m_have, m_lock, m_valid, m_serr, m_wrap;
    int m_R, m_run, m_idx, m_oh, m_ecnt, m_ecnt2, m_wcnt;

    logic [24:0] obs;
    assign obs = {phase_idx, phase_onehot, valid_code, locked, step_err, wrap_pulse,
                  err_count, err_count_s};

    function automatic logic [24:0] expv();
        return {3'(m_idx), 8'(m_oh), m_valid, m_lock, m_serr, m_wrap, 8'(m_ecnt), 2'(m_ecnt2)};
    endfunction

    function automatic int idx_of(input logic [3:0] c);
        for (int k = 0; k < NPH; k++) if (codes[k] == c) return k;
        return -1;
    endfunction

    task automatic model_reset();
        m_have = 0; m_lock = 0; m_valid = 0; m_serr = 0; m_wrap = 0;
        m_R = 0; m_run = 0; m_idx = 0; m_oh = 0; m_ecnt = 0; m_ecnt2 = 0; m_wcnt = 0;
    endtask

    task automatic model_update(input logic e, input logic [3:0] c, input logic clr);
        int i;
        m_serr = 0;
        m_wrap = 0;
        if (e) begin
            i = idx_of(c);
            m_valid = (i >= 0);
            if (i >= 0) begin m_idx = i; m_oh = 1 << i; end
            else m_oh = 0;
            if (!m_have) begin
                if (i >= 0) begin m_have = 1; m_R = i; m_run = 0; end
            end else if (i < 0) begin
                m_serr = 1; m_have = 0; m_lock = 0; m_run = 0;
            end else if (i != m_R) begin
                if (i == (m_R + 1) % NPH) begin
                    if (m_lock) m_wrap = (m_R == NPH - 1) && (i == 0);
                    else begin
                        m_run++;
                        if (m_run == LOCKN) m_lock = 1;
                    end
                    m_R = i;
                end else begin
                    m_serr = 1; m_lock = 0; m_run = 0; m_R = i;
                end
            end
        end
        if (clr) begin
            m_ecnt = 0; m_ecnt2 = 0; m_wcnt = 0;
        end else begin
            if (m_serr) begin
                if (m_ecnt < 255) m_ecnt++;
                if (m_ecnt2 < 3)  m_ecnt2++;
            end
            if (m_wrap) m_wcnt = (m_wcnt + 1) % 65536;
        end
    endtask

    // Apply one sample, advance one clock, update the model, settle 1 time unit.
    task automatic step(input logic e, input logic [3:0] c, input logic clr);
        en = e; count_in = c; clear_err = clr;
        @(posedge clk);
        model_update(e, c, clr);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            count_in = 4'($urandom);
            @(posedge clk); #1;
            vectors++;
            if (obs !== 25'd0) begin $display("FAIL reset_hold obs=%h exp=0", obs); fails++; end
        end
        reset = 1'b1;
        step(1'b1, codes[0], 1'b0);
        vectors++;
        if (obs !== expv()) begin $display("FAIL reset_first obs=%h exp=%h", obs, expv()); fails++; end
        vectors++;
        if ({phase_idx, valid_code, locked} !== {3'd0, 1'b1, 1'b0}) begin
            $display("FAIL reset_first_fields idx=%0d valid=%b locked=%b exp 0/1/0", phase_idx, valid_code, locked);
            fails++;
        end
    endtask

    task automatic test_lock();
        for (int k = 0; k <= 4; k++) begin
            step(1'b1, codes[k], 1'b0);
            vectors++;
            if (obs !== expv()) begin $display("FAIL lock_model k=%0d obs=%h exp=%h", k, obs, expv()); fails++; end
            vectors++;
            if ({phase_idx, locked, step_err} !== {3'(k), (k == 4), 1'b0}) begin
                $display("FAIL lock_seq k=%0d idx=%0d locked=%b serr=%b", k, phase_idx, locked, step_err);
                fails++;
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_oh [4] = '{8'h20, 8'h40, 8'h80, 8'h01};
        for (int k = 0; k < 4; k++) begin
            step(1'b1, codes[(5 + k) % 8], 1'b0);
            vectors++;
            if (obs !== expv()) begin $display("FAIL wrap_model k=%0d obs=%h exp=%h", k, obs, expv()); fails++; end
            vectors++;
            if ({phase_onehot, wrap_pulse} !== {exp_oh[k], (k == 3)}) begin
                $display("FAIL wrap_seq k=%0d oh=%h wrap=%b exp oh=%h wrap=%b", k, phase_onehot, wrap_pulse, exp_oh[k], (k == 3));
                fails++;
            end
        end
    endtask

    task automatic test_stall_gating();
        step(1'b1, codes[1], 1'b0);
        step(1'b1, codes[2], 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i < 3) step(1'b1, codes[2], 1'b0);
            else       step(1'b0, 4'($urandom), 1'b0);
            vectors++;
            if (obs !== expv()) begin $display("FAIL stall_model i=%0d obs=%h exp=%h", i, obs, expv()); fails++; end
            vectors++;
            if ({phase_idx, locked, step_err} !== {3'd2, 1'b1, 1'b0}) begin
                $display("FAIL stall_hold i=%0d idx=%0d locked=%b serr=%b exp 2/1/0", i, phase_idx, locked, step_err);
                fails++;
            end
        end
    endtask

    task automatic test_errors();
        step(1'b1, 4'b1111, 1'b0);
        vectors++;
        if ({step_err, locked, err_count} !== {1'b1, 1'b0, 8'd1}) begin
            $display("FAIL skip_err serr=%b locked=%b cnt=%0d exp 1/0/1", step_err, locked, err_count);
            fails++;
        end
        for (int k = 5; k <= 8; k++) begin
            step(1'b1, codes[k % 8], 1'b0);
            vectors++;
            if (obs !== expv()) begin $display("FAIL relock_model k=%0d obs=%h exp=%h", k, obs, expv()); fails++; end
        end
        vectors++;
        if (locked !== 1'b1) begin $display("FAIL relock locked=%b exp 1", locked); fails++; end
        step(1'b1, 4'b1010, 1'b0);
        vectors++;
        if ({valid_code, phase_onehot, err_count, locked} !== {1'b0, 8'h00, 8'd2, 1'b0}) begin
            $display("FAIL ill_err valid=%b oh=%h cnt=%0d locked=%b exp 0/00/2/0", valid_code, phase_onehot, err_count, locked);
            fails++;
        end
        step(1'b1, codes[0], 1'b0);
        step(1'b1, codes[3], 1'b1);
        vectors++;
        if ({step_err, err_count} !== {1'b1, 8'd0}) begin
            $display("FAIL clear_wins serr=%b cnt=%0d exp 1/0", step_err, err_count);
            fails++;
        end
        vectors++;
        if (obs !== expv()) begin $display("FAIL errors_model obs=%h exp=%h", obs, expv()); fails++; end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'b1010, 1'b0);
            step(1'b1, codes[0], 1'b0);
            vectors++;
            if (obs !== expv()) begin $display("FAIL sat_model i=%0d obs=%h exp=%h", i, obs, expv()); fails++; end
        end
        vectors++;
        if ({err_count, err_count_s} !== {8'd5, 2'd3}) begin
            $display("FAIL saturate cnt=%0d cnt_s=%0d exp 5/3", err_count, err_count_s);
            fails++;
        end
    endtask

    task automatic test_revolutions();
        int wraps = 0;
        for (int k = 1; k <= 28; k++) begin
            step(1'b1, codes[k % 8], 1'b0);
            if (wrap_pulse === 1'b1) wraps++;
            vectors++;
            if (obs !== expv()) begin $display("FAIL rev_model k=%0d obs=%h exp=%h", k, obs, expv()); fails++; end
        end
        vectors++;
        if (wraps !== 3) begin $display("FAIL rev_wraps got=%0d exp 3", wraps); fails++; end
`ifdef JOHNSON_PHASE_WRAP_CNT_EN
        vectors++;
        if (wrap_count !== 16'd3) begin $display("FAIL wrap_count got=%0d exp 3", wrap_count); fails++; end
`endif
    endtask

    task automatic test_async_reset();
        #2 reset = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (obs !== 25'd0) begin $display("FAIL async_reset obs=%h exp=0", obs); fails++; end
`ifdef JOHNSON_PHASE_WRAP_CNT_EN
        vectors++;
        if (wrap_count !== 16'd0) begin $display("FAIL async_reset_wcnt got=%0d exp 0", wrap_count); fails++; end
`endif
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, codes[6], 1'b0);
        vectors++;
        if (obs !== expv()) begin $display("FAIL post_reset obs=%h exp=%h", obs, expv()); fails++; end
    endtask

    task automatic test_random();
        logic [3:0] c;
        int r;
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 60)      c = codes[(m_R + 1) % NPH];
            else if (r < 75) c = codes[m_R];
            else if (r < 85) c = codes[$urandom_range(0, 7)];
            else             c = 4'($urandom);
            step(($urandom % 8) != 0, c, ($urandom % 32) == 0);
            vectors++;
            if (obs !== expv()) begin $display("FAIL random i=%0d obs=%h exp=%h", i, obs, expv()); fails++; end
`ifdef JOHNSON_PHASE_WRAP_CNT_EN
            vectors++;
            if (wrap_count !== 16'(m_wcnt)) begin
                $display("FAIL random_wcnt i=%0d got=%0d exp=%0d", i, wrap_count, m_wcnt);
                fails++;
            end
`endif
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_lock();
        test_wrap();
        test_stall_gating();
        test_errors();
        test_saturation();
        test_revolutions();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
